// File: rtl/spi_arbiter_if.sv
// Frame-engine side of the SPI arbiter: one frame is launched while spi_en is high,
// and the engine reports each finished frame with a one-cycle spi_done.
interface spi_arbiter_if;
  logic        spi_en;
  logic [15:0] spi_sdata;
  logic [1:0]  spi_mode;
  logic        spi_done;
  logic [15:0] spi_rdata;

  modport master (output spi_en, spi_sdata, spi_mode, input spi_done, spi_rdata);
  modport slave  (input spi_en, spi_sdata, spi_mode, output spi_done, spi_rdata);
endinterface

// File: rtl/spi_arbiter.sv
// Two-requester round-robin arbiter in front of a shared SPI frame engine.
// It runs multi-frame transactions with a watchdog, followed by a fixed idle gap.
module spi_arbiter #(
  parameter int GAP_CYC = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [1:0]  req,
  input  logic [3:0]  nframes0,
  input  logic [3:0]  nframes1,
  input  logic [15:0] sdata0,
  input  logic [15:0] sdata1,
  input  logic [1:0]  mode0,
  input  logic [1:0]  mode1,
  output logic [1:0]  gnt,
  output logic [1:0]  frame_done,
  output logic [1:0]  xfer_done,
  output logic [15:0] rdata,
  output logic        err,
  spi_arbiter_if.master spi
);
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t      r_state;
  logic        r_gidx, r_last, r_en, r_err;
  logic [1:0]  r_gnt, r_fdone, r_xdone, r_mode_hold;
  logic [3:0]  r_nleft;
  logic [15:0] r_wdog, r_rdata;
  logic [9:0]  r_gap;

  logic        w_win;
  logic [3:0]  w_nf;
  logic [15:0] w_sdata;
  logic [1:0]  w_mode;

  // On a tie, the requester that was not served last wins.
  assign w_win   = (req == 2'b11) ? ~r_last : req[1];
  assign w_nf    = w_win ? nframes1 : nframes0;
  assign w_sdata = r_gidx ? sdata1 : sdata0;
  assign w_mode  = r_gidx ? mode1 : mode0;

  assign spi.spi_en    = r_en;
  assign spi.spi_sdata = (r_state == ACTIVE) ? w_sdata : '0;
  assign spi.spi_mode  = (r_state == ACTIVE) ? w_mode : r_mode_hold;

  assign gnt        = r_gnt;
  assign frame_done = r_fdone;
  assign xfer_done  = r_xdone;
  assign rdata      = r_rdata;
  assign err        = r_err;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= IDLE;
      r_gidx      <= 1'b0;
      r_last      <= 1'b1;
      r_en        <= 1'b0;
      r_err       <= 1'b0;
      r_gnt       <= '0;
      r_fdone     <= '0;
      r_xdone     <= '0;
      r_mode_hold <= '0;
      r_nleft     <= '0;
      r_wdog      <= '0;
      r_rdata     <= '0;
      r_gap       <= '0;
    end else begin
      r_fdone <= '0;
      r_xdone <= '0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: if (|req) begin
          r_state <= ACTIVE;
          r_gidx  <= w_win;
          r_gnt   <= w_win ? 2'b10 : 2'b01;
          r_en    <= 1'b1;
          r_nleft <= (w_nf == 4'd0) ? 4'd1 : w_nf;
          r_wdog  <= '0;
        end
        ACTIVE: begin
          r_mode_hold <= w_mode;
          // spi_done is checked first so a frame finishing on the expiry cycle completes normally
          if (spi.spi_done) begin
            r_rdata <= spi.spi_rdata;
            r_fdone <= r_gnt;
            r_wdog  <= '0;
            r_nleft <= r_nleft - 4'd1;
            if (r_nleft == 4'd1) begin
              r_xdone <= r_gnt;
              r_en    <= 1'b0;
              r_gnt   <= '0;
              r_last  <= r_gidx;
              r_gap   <= '0;
              r_state <= GAP;
            end
          end else if (r_wdog == 16'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_en    <= 1'b0;
            r_gnt   <= '0;
            r_last  <= r_gidx;
            r_gap   <= '0;
            r_state <= GAP;
          end else begin
            r_wdog <= r_wdog + 16'd1;
          end
        end
        GAP: begin
          if (r_gap == 10'(GAP_CYC - 1)) r_state <= IDLE;
          else                           r_gap   <= r_gap + 10'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: the stimulus queues the expected events and a
// negedge monitor pops and compares them as grant/frame/xfer/err events appear.
module tb_spi_arbiter;
  localparam int GAP_CYC = 16;
  localparam int TIMEOUT = 64;
  localparam int K_GNT = 0, K_FRM = 1, K_XFR = 2, K_ERR = 3;

  typedef struct {
    int          kind;
    int          idx;
    logic [15:0] data;
    int          dt;   // GNT: spi_en low cycles before grant; others: cycles since grant; -1 = any
  } ev_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [1:0]  req;
  logic [3:0]  nframes0, nframes1;
  logic [15:0] sdata0, sdata1;
  logic [1:0]  mode0, mode1;
  logic [1:0]  gnt, frame_done, xfer_done;
  logic [15:0] rdata;
  logic        err;

  spi_arbiter_if spi_if ();

  spi_arbiter #(.GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req(req),
    .nframes0(nframes0), .nframes1(nframes1), .sdata0(sdata0), .sdata1(sdata1),
    .mode0(mode0), .mode1(mode1), .gnt(gnt), .frame_done(frame_done),
    .xfer_done(xfer_done), .rdata(rdata), .err(err), .spi(spi_if)
  );

  always #10 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int idx, input logic [15:0] data, input int dt);
    ev_t e;
    e.kind = kind; e.idx = idx; e.data = data; e.dt = dt;
    exp_q.push_back(e);
  endtask

  task automatic sb(input int kind, input int idx, input logic [15:0] data, input int dt);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind=%0d idx=%0d data=%h dt=%0d expected no event",
               kind, idx, data, dt);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.idx != idx || (kind == K_FRM && e.data !== data) ||
          (e.dt >= 0 && e.dt != dt)) begin
        errors++;
        $display("FAIL sb_event: got kind=%0d idx=%0d data=%h dt=%0d expected kind=%0d idx=%0d data=%h dt=%0d",
                 kind, idx, data, dt, e.kind, e.idx, e.data, e.dt);
      end
    end
  endtask

  // Monitor: decoupled from stimulus, samples on the falling edge.
  initial begin
    logic [1:0]  prev_gnt;
    logic [15:0] exp_sd;
    int          low_run, g_cyc;
    prev_gnt = '0; low_run = -1; g_cyc = 0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        prev_gnt = '0;
        low_run  = -1;
      end else begin
        if (gnt != 2'b00 && prev_gnt == 2'b00) begin
          sb(K_GNT, int'(gnt[1]), 16'h0, low_run);
          g_cyc = cyc;
        end
        if (|frame_done) sb(K_FRM, int'(frame_done[1]), rdata, cyc - g_cyc);
        if (|xfer_done)  sb(K_XFR, int'(xfer_done[1]), 16'h0, cyc - g_cyc);
        if (err)         sb(K_ERR, 0, 16'h0, cyc - g_cyc);
        exp_sd = (gnt == 2'b01) ? sdata0 : (gnt == 2'b10) ? sdata1 : 16'h0;
        checks++;
        if ($countones(gnt) > 1 || $countones(frame_done) > 1 || $countones(xfer_done) > 1 ||
            spi_if.spi_en != (gnt != 2'b00) || spi_if.spi_sdata !== exp_sd ||
            (gnt == 2'b01 && spi_if.spi_mode !== mode0) ||
            (gnt == 2'b10 && spi_if.spi_mode !== mode1)) begin
          errors++;
          $display("FAIL invariant @%0d: gnt=%b fd=%b xd=%b en=%b sdata=%h mode=%0d expected sdata=%h",
                   cyc, gnt, frame_done, xfer_done, spi_if.spi_en, spi_if.spi_sdata,
                   spi_if.spi_mode, exp_sd);
        end
        if (spi_if.spi_en) low_run = 0;
        else if (low_run >= 0) low_run++;
        prev_gnt = gnt;
      end
    end
  end

  task automatic step();
    @(posedge sys_clk); #1;
  endtask

  task automatic pulse_done_at(input int target, input logic [15:0] d);
    while (cyc < target) step();
    spi_if.spi_done  = 1'b1;
    spi_if.spi_rdata = d;
    step();
    spi_if.spi_done = 1'b0;
  endtask

  task automatic wait_gnt(output int g);
    int n;
    n = 0;
    while (gnt == 2'b00 && n < 200) begin step(); n++; end
    if (gnt == 2'b00) begin
      checks++; errors++;
      $display("FAIL wait_gnt: got no grant within 200 cycles expected a grant");
    end
    g = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 1 ms");
    $fatal(1, "global timeout");
  end

  initial begin
    int g;
    sys_rst_n = 1'b0; req = '0;
    nframes0 = '0; nframes1 = '0; sdata0 = '0; sdata1 = '0; mode0 = '0; mode1 = '0;
    spi_if.spi_done = 1'b0; spi_if.spi_rdata = '0;
    repeat (3) step();
    chk("rst_gnt", gnt, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_xdone", xfer_done, 0);
    chk("rst_err", err, 0);
    chk("rst_en", spi_if.spi_en, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mode", spi_if.spi_mode, 0);
    sys_rst_n = 1'b1;
    step();

    // spi_done while idle is ignored
    pulse_done_at(cyc + 2, 16'hBEEF);
    repeat (3) step();
    chk("idle_done_rdata", rdata, 0);

    // three-frame transaction; req dropped right after the grant
    sdata0 = 16'hA5A5; mode0 = 2'd2; nframes0 = 4'd3; req = 2'b01;
    push(K_GNT, 0, 0, -1);
    wait_gnt(g);
    req = 2'b00;
    push(K_FRM, 0, 16'h0011, 40);
    push(K_FRM, 0, 16'h0022, 80);
    push(K_FRM, 0, 16'h00EF, 120);
    push(K_XFR, 0, 0, 120);
    pulse_done_at(g + 39,  16'h0011);
    pulse_done_at(g + 79,  16'h0022);
    pulse_done_at(g + 119, 16'h00EF);
    step();
    chk("gap_mode_hold", spi_if.spi_mode, 2);
    chk("gap_sdata", spi_if.spi_sdata, 0);
    chk("xfer_rdata", rdata, 16'h00EF);
    pulse_done_at(cyc + 1, 16'hDEAD);
    chk("gap_done_rdata", rdata, 16'h00EF);

    // nframes 0 acts as one frame; grant waits GAP_CYC gap cycles plus one idle cycle
    nframes1 = 4'd0; sdata1 = 16'h5A5A; mode1 = 2'd1; req = 2'b10;
    push(K_GNT, 1, 0, GAP_CYC + 1);
    wait_gnt(g);
    req = 2'b00;
    push(K_FRM, 1, 16'h1234, 5);
    push(K_XFR, 1, 0, 5);
    pulse_done_at(g + 4, 16'h1234);

    // both requesting: grants alternate 0,1,0,1
    nframes0 = 4'd1; nframes1 = 4'd1; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      push(K_GNT, k % 2, 0, GAP_CYC + 1);
      wait_gnt(g);
      if (k == 3) req = 2'b00;
      push(K_FRM, k % 2, 16'h0100 + 16'(k), 3);
      push(K_XFR, k % 2, 0, 3);
      pulse_done_at(g + 2, 16'h0100 + 16'(k));
    end

    // watchdog abort on requester 1
    req = 2'b10;
    push(K_GNT, 1, 0, GAP_CYC + 1);
    wait_gnt(g);
    req = 2'b00;
    push(K_ERR, 0, 0, TIMEOUT);
    while (cyc < g + TIMEOUT + 6) step();

    // abort still counts as last grant, so a tie goes to 0; spi_done on expiry cycle completes
    req = 2'b11;
    push(K_GNT, 0, 0, GAP_CYC + 1);
    wait_gnt(g);
    req = 2'b00;
    push(K_FRM, 0, 16'h0BAD, TIMEOUT);
    push(K_XFR, 0, 0, TIMEOUT);
    pulse_done_at(g + TIMEOUT - 1, 16'h0BAD);

    // reset in the middle of frame 2 of 3
    nframes0 = 4'd3; req = 2'b01;
    push(K_GNT, 0, 0, GAP_CYC + 1);
    wait_gnt(g);
    push(K_FRM, 0, 16'h0077, 10);
    pulse_done_at(g + 9, 16'h0077);
    while (cyc < g + 15) step();
    sys_rst_n = 1'b0;
    #2;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_en", spi_if.spi_en, 0);
    chk("midrst_fdone", frame_done, 0);
    chk("midrst_xdone", xfer_done, 0);
    chk("midrst_rdata", rdata, 0);
    req = 2'b11; nframes0 = 4'd1;
    step(); step();
    push(K_GNT, 0, 0, -1);
    sys_rst_n = 1'b1;
    wait_gnt(g);
    req = 2'b00;
    push(K_FRM, 0, 16'h0042, 3);
    push(K_XFR, 0, 0, 3);
    pulse_done_at(g + 2, 16'h0042);

    repeat (30) step();
    chk("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
